alu_sequencer: RTL

- Multi-cycle control FSM for the 16-bit ALU datapath. It fetches instruction words over a memory handshake, decodes the 8-bit opcode, and drives ALU op and register-file addresses.
- Sequences memory and IO transfers, handles control flow (JMP/JMA/CLL/RET) through an internal return stack, and latches the ALU overflow and compare flags.
- Sits between program/data memory, the register file and the ALU; it is the CPU core's only control source.

---
 rtl/alu_sequencer_pkg.sv | 68 ++++++
 rtl/alu_sequencer_ret_stack.sv | 48 ++++
 rtl/alu_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - opcodes, FSM states, write-mux selects and opcode classes
package alu_sequencer_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_NOT = 8'h01;
  localparam logic [7:0] OP_XOR = 8'h02;
  localparam logic [7:0] OP_OR  = 8'h03;
  localparam logic [7:0] OP_AND = 8'h04;
  localparam logic [7:0] OP_SUB = 8'h05;
  localparam logic [7:0] OP_ADD = 8'h06;
  localparam logic [7:0] OP_RR  = 8'h07;
  localparam logic [7:0] OP_RL  = 8'h08;
  localparam logic [7:0] OP_DEC = 8'h09;
  localparam logic [7:0] OP_INC = 8'h0A;
  localparam logic [7:0] OP_RST = 8'h0B;
  localparam logic [7:0] OP_CMP = 8'h0C;
  localparam logic [7:0] OP_LDI = 8'h10;
  localparam logic [7:0] OP_JMP = 8'h11;
  localparam logic [7:0] OP_JMA = 8'h12;
  localparam logic [7:0] OP_CLL = 8'h13;
  localparam logic [7:0] OP_RET = 8'h14;
  localparam logic [7:0] OP_LD  = 8'h20;
  localparam logic [7:0] OP_ST  = 8'h21;
  localparam logic [7:0] OP_IOR = 8'h22;
  localparam logic [7:0] OP_IOW = 8'h23;

  localparam logic [2:0] ST_FETCH   = 3'd0;
  localparam logic [2:0] ST_OPERAND = 3'd1;
  localparam logic [2:0] ST_EXEC    = 3'd2;
  localparam logic [2:0] ST_MEM     = 3'd3;
  localparam logic [2:0] ST_TRAP    = 3'd4;

  localparam logic [1:0] RF_SEL_ALU = 2'd0;
  localparam logic [1:0] RF_SEL_MEM = 2'd1;
  localparam logic [1:0] RF_SEL_IMM = 2'd2;

  function automatic logic is_two_word(input logic [7:0] op);
    case (op)
      OP_LDI, OP_JMP, OP_JMA, OP_CLL,
      OP_LD, OP_ST, OP_IOR, OP_IOW: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  function automatic logic is_alu_write(input logic [7:0] op);
    case (op)
      OP_NOT, OP_XOR, OP_OR, OP_AND, OP_SUB, OP_ADD,
      OP_RR, OP_RL, OP_DEC, OP_INC, OP_RST: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  function automatic logic sets_ovf(input logic [7:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic is_defined(input logic [7:0] op);
    case (op)
      OP_NOP, OP_CMP, OP_LDI, OP_JMP, OP_JMA, OP_CLL, OP_RET,
      OP_LD, OP_ST, OP_IOR, OP_IOW: return 1'b1;
      default:                      return is_alu_write(op);
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_ret_stack.sv
// rtl/alu_sequencer_ret_stack.sv - LIFO of return addresses for CLL/RET
module ret_stack
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_sp;
  logic [PTR_W-1:0] w_wr_idx;
  logic [PTR_W-1:0] w_rd_idx;

  // r_sp counts entries, so one extra bit distinguishes full from empty
  assign w_wr_idx = r_sp[PTR_W-1:0];
  assign w_rd_idx = w_wr_idx - 1'b1;
  assign o_full   = (r_sp == (PTR_W+1)'(DEPTH));
  assign o_empty  = (r_sp == '0);
  assign o_data   = r_mem[w_rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp <= '0;
    end else if (i_push && !o_full) begin
      r_sp <= r_sp + 1'b1;
    end else if (i_pop && !o_empty) begin
      r_sp <= r_sp - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !o_full) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle fetch/decode/execute control FSM for the 16-bit ALU core
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_io,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic [3:0]        rf_ra,
  output logic [3:0]        rf_rb,
  input  logic [WIDTH-1:0]  rf_rdata_a,
  output logic              rf_we,
  output logic [3:0]        rf_wa,
  output logic [1:0]        rf_sel,
  output logic [WIDTH-1:0]  imm,
  output logic [7:0]        alu_op,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic              alu_ovf,
  output logic              flag_c,
  output logic              flag_v,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [WIDTH-1:0]  r_ir;
  logic [WIDTH-1:0]  r_imm;
  logic              r_flag_c;
  logic              r_flag_v;

  logic [7:0]        w_op;
  logic [3:0]        w_rd;
  logic [3:0]        w_rs;
  logic              w_in_exec;
  logic              w_in_mem;
  logic              w_wb_load;
  logic              w_push;
  logic              w_pop;
  logic              w_stk_full;
  logic              w_stk_empty;
  logic [ADDR_W-1:0] w_stk_top;
  logic [ADDR_W-1:0] w_target;
  logic              w_unused;

  assign w_op      = r_ir[15:8];
  assign w_rd      = r_ir[7:4];
  assign w_rs      = r_ir[3:0];
  assign w_in_exec = (r_state == ST_EXEC);
  assign w_in_mem  = (r_state == ST_MEM);
  assign w_wb_load = (w_op == OP_LD) || (w_op == OP_IOR);
  assign w_target  = ADDR_W'(r_imm);
  assign w_push    = w_in_exec && (w_op == OP_CLL) && !w_stk_full;
  assign w_pop     = w_in_exec && (w_op == OP_RET) && !w_stk_empty;
  assign w_unused  = ^alu_out[WIDTH-1:1];

  ret_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (r_pc),
    .o_data  (w_stk_top),
    .o_full  (w_stk_full),
    .o_empty (w_stk_empty)
  );

  // Port A reads rs during MEM so the store data comes straight off the register file
  assign rf_ra     = w_in_mem ? w_rs : w_rd;
  assign rf_rb     = w_rs;
  assign rf_wa     = w_rd;
  assign mem_wdata = rf_rdata_a;
  assign imm       = r_imm;
  assign flag_c    = r_flag_c;
  assign flag_v    = r_flag_v;
  assign pc        = r_pc;
  assign halted    = (r_state == ST_TRAP);

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_io   = 1'b0;
    mem_addr = r_pc;
    rf_we    = 1'b0;
    rf_sel   = RF_SEL_ALU;
    alu_op   = OP_NOP;
    case (r_state)
      ST_FETCH, ST_OPERAND: begin
        mem_req = 1'b1;
      end
      ST_EXEC: begin
        alu_op = w_op;
        rf_we  = is_alu_write(w_op) || (w_op == OP_LDI);
        if (w_op == OP_LDI) begin
          rf_sel = RF_SEL_IMM;
        end
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        mem_addr = w_target;
        mem_io   = (w_op == OP_IOR) || (w_op == OP_IOW);
        mem_we   = (w_op == OP_ST) || (w_op == OP_IOW);
        rf_we    = mem_ack && w_wb_load;
        rf_sel   = RF_SEL_MEM;
      end
      default: begin
      end
    endcase
    // Reset must kill strobes in the same instant, not at the next edge
    if (rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      rf_we   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_FETCH;
      r_pc     <= '0;
      r_ir     <= '0;
      r_imm    <= '0;
      r_flag_c <= 1'b0;
      r_flag_v <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (mem_ack) begin
            r_ir    <= mem_rdata;
            r_pc    <= r_pc + 1'b1;
            r_state <= is_two_word(mem_rdata[15:8]) ? ST_OPERAND : ST_EXEC;
          end
        end
        ST_OPERAND: begin
          if (mem_ack) begin
            r_imm   <= mem_rdata;
            r_pc    <= r_pc + 1'b1;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_state <= ST_FETCH;
          if (sets_ovf(w_op)) begin
            r_flag_v <= alu_ovf;
          end
          case (w_op)
            OP_CMP: r_flag_c <= alu_out[0];
            OP_JMP: r_pc <= w_target;
            OP_JMA: begin
              if (r_flag_c) begin
                r_pc <= w_target;
              end
            end
            OP_CLL: begin
              if (w_stk_full) begin
                r_state <= ST_TRAP;
              end else begin
                r_pc <= w_target;
              end
            end
            OP_RET: begin
              if (w_stk_empty) begin
                r_state <= ST_TRAP;
              end else begin
                r_pc <= w_stk_top;
              end
            end
            OP_LD, OP_ST, OP_IOR, OP_IOW: r_state <= ST_MEM;
            default: begin
              if (!is_defined(w_op)) begin
                r_state <= ST_TRAP;
              end
            end
          endcase
        end
        ST_MEM: begin
          if (mem_ack) begin
            r_state <= ST_FETCH;
          end
        end
        ST_TRAP: begin
        end
        default: r_state <= ST_TRAP;
      endcase
    end
  end

endmodule
